// File: rtl/alg_ip_frm_mon.sv
// alg_ip_frm_mon: frame start/end monitor producing frm_done strobes, frame stats and sticky protocol errors.
module alg_ip_frm_mon #(
  parameter int          CNT_W   = 32,
  parameter int          FRM_W   = 16,
  parameter int unsigned TIMEOUT = 1000000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             frm_start_i,
  input  logic             frm_end_i,
  input  logic             err_clr_i,
  output logic             frm_done_o,
  output logic             in_frame_o,
  output logic [FRM_W-1:0] frame_count_o,
  output logic [CNT_W-1:0] frm_cycles_o,
  output logic             err_orphan_end_o,
  output logic             err_overlap_o,
  output logic             err_timeout_o
);
  typedef enum logic {IDLE, ACTIVE} st_t;
  localparam logic [CNT_W-1:0] TO_C = CNT_W'(TIMEOUT);
  st_t              st_q, st_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc, cyc_q, cyc_d;
  logic [FRM_W-1:0] fc_q, fc_d;
  logic             done_q, done_d, orp_q, orp_d, ov_q, ov_d, to_q, to_d;
  logic             act, tmo, set_orp, set_ov;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) st_q <= IDLE;
    else       st_q <= st_d;
  end
  // a timed-out frame swallows any frm_end in the same cycle
  always_comb begin
    act  = st_q == ACTIVE;
    tmo  = (TIMEOUT != 0) && act && cnt_q == TO_C;
    st_d = act ? ((tmo || frm_end_i) ? (frm_start_i ? ACTIVE : IDLE) : ACTIVE)
               : ((frm_start_i && !frm_end_i) ? ACTIVE : IDLE);
  end
  always_comb begin
    cnt_inc = &cnt_q ? cnt_q : cnt_q + CNT_W'(1);
    done_d  = !tmo && frm_end_i && (act || frm_start_i);
    set_orp = !act && frm_end_i && !frm_start_i;
    set_ov  = act && !tmo && frm_start_i && !frm_end_i;
    cnt_d   = st_d == ACTIVE ? (frm_start_i ? CNT_W'(1) : cnt_inc) : '0;
    cyc_d   = done_d ? (act ? cnt_inc : CNT_W'(1)) : cyc_q;
    fc_d    = fc_q + FRM_W'(done_d);
    orp_d   = set_orp || (orp_q && !err_clr_i);
    ov_d    = set_ov || (ov_q && !err_clr_i);
    to_d    = tmo || (to_q && !err_clr_i);
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      cyc_q  <= '0;
      fc_q   <= '0;
      done_q <= 1'b0;
      orp_q  <= 1'b0;
      ov_q   <= 1'b0;
      to_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      cyc_q  <= cyc_d;
      fc_q   <= fc_d;
      done_q <= done_d;
      orp_q  <= orp_d;
      ov_q   <= ov_d;
      to_q   <= to_d;
    end
  end
  always_comb begin
    in_frame_o       = st_q == ACTIVE;
    frm_done_o       = done_q;
    frame_count_o    = fc_q;
    frm_cycles_o     = cyc_q;
    err_orphan_end_o = orp_q;
    err_overlap_o    = ov_q;
    err_timeout_o    = to_q;
  end
endmodule

// File: tb/tb_alg_ip_frm_mon.sv
// tb_alg_ip_frm_mon: directed bench checking two monitor instances against an event-time model.
module tb_alg_ip_frm_mon;
  logic clk = 1'b0, rst, s = 1'b0, e = 1'b0, c = 1'b0;
  logic d0, f0, o0, v0, t0, d1, f1, o1, v1, t1;
  logic [15:0] fc0;
  logic [1:0]  fc1;
  logic [31:0] cy0, cy1;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;

  alg_ip_frm_mon u0 (
    .clk_i(clk), .rst_i(rst), .frm_start_i(s), .frm_end_i(e), .err_clr_i(c),
    .frm_done_o(d0), .in_frame_o(f0), .frame_count_o(fc0), .frm_cycles_o(cy0),
    .err_orphan_end_o(o0), .err_overlap_o(v0), .err_timeout_o(t0));

  alg_ip_frm_mon #(.CNT_W(32), .FRM_W(2), .TIMEOUT(8)) u1 (
    .clk_i(clk), .rst_i(rst), .frm_start_i(s), .frm_end_i(e), .err_clr_i(c),
    .frm_done_o(d1), .in_frame_o(f1), .frame_count_o(fc1), .frm_cycles_o(cy1),
    .err_orphan_end_o(o1), .err_overlap_o(v1), .err_timeout_o(t1));

  // model: frames tracked by the edge index at which they opened
  int ed = 0;
  bit m_open[2], m_done[2], m_orp[2], m_ov[2], m_to[2];
  int m_ts[2], m_cnt[2];
  longint m_cyc[2];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_open[i] = 0; m_done[i] = 0; m_orp[i] = 0; m_ov[i] = 0; m_to[i] = 0;
        m_ts[i] = 0; m_cnt[i] = 0; m_cyc[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        int lim, fw;
        lim = i ? 8 : 1000000;
        fw  = i ? 2 : 16;
        m_done[i] = 0;
        if (c) begin m_orp[i] = 0; m_ov[i] = 0; m_to[i] = 0; end
        if (m_open[i] && ed - m_ts[i] == lim) begin
          m_to[i] = 1; m_open[i] = s; m_ts[i] = ed;
        end else if (m_open[i] && e) begin
          m_done[i] = 1; m_cyc[i] = ed - m_ts[i] + 1; m_cnt[i] = (m_cnt[i] + 1) % (1 << fw);
          m_open[i] = s; m_ts[i] = ed;
        end else if (m_open[i] && s) begin
          m_ov[i] = 1; m_ts[i] = ed;
        end else if (s && e) begin
          m_done[i] = 1; m_cyc[i] = 1; m_cnt[i] = (m_cnt[i] + 1) % (1 << fw);
        end else if (s) begin
          m_open[i] = 1; m_ts[i] = ed;
        end else if (e) m_orp[i] = 1;
      end
      ed++;
    end
  end

  task automatic cmp(input string n, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %0d expected %0d at %0t", n, got, exp, $time);
    end
  endtask

  always @(negedge clk) if (!rst) begin
    cmp("u0.frm_done", d0, m_done[0]);   cmp("u1.frm_done", d1, m_done[1]);
    cmp("u0.in_frame", f0, m_open[0]);   cmp("u1.in_frame", f1, m_open[1]);
    cmp("u0.frame_count", fc0, m_cnt[0]); cmp("u1.frame_count", fc1, m_cnt[1]);
    cmp("u0.frm_cycles", cy0, m_cyc[0]); cmp("u1.frm_cycles", cy1, m_cyc[1]);
    cmp("u0.err_orphan", o0, m_orp[0]);  cmp("u1.err_orphan", o1, m_orp[1]);
    cmp("u0.err_overlap", v0, m_ov[0]);  cmp("u1.err_overlap", v1, m_ov[1]);
    cmp("u0.err_timeout", t0, m_to[0]);  cmp("u1.err_timeout", t1, m_to[1]);
  end

  task automatic cy(input logic ss, input logic ee, input logic cc = 1'b0);
    s = ss; e = ee; c = cc;
    @(negedge clk);
    s = 1'b0; e = 1'b0; c = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cy(1'b0, 1'b0);
  endtask

  task automatic zeros(input string n);
    cmp({n, ".u0_all"}, {d0, f0, o0, v0, t0, fc0, cy0}, 0);
    cmp({n, ".u1_all"}, {d1, f1, o1, v1, t1, fc1, cy1}, 0);
  endtask

  // reset asserted between clock edges; outputs must clear before the next edge
  task automatic rst_pulse(input string n);
    #2 rst = 1'b1;
    #1 zeros(n);
    #1 rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    #6 zeros("por");
    @(negedge clk);
    rst = 1'b0;
    // basic frame: start@5, end@14 -> 10 cycles (u1 times out instead)
    idle(5);
    cy(1, 0);
    cmp("basic.in_frame", f0, 1);
    idle(8);
    cy(0, 1);
    cmp("basic.done", d0, 1); cmp("basic.cycles", cy0, 10); cmp("basic.count", fc0, 1);
    cmp("basic.in_frame_off", f0, 0); cmp("basic.u1_timeout", t1, 1);
    idle(1);
    cmp("basic.done_once", d0, 0);
    rst_pulse("rst1");
    // back-to-back
    cy(1, 0); idle(2); cy(1, 1);
    cmp("b2b.done1", d0, 1); cmp("b2b.cycles1", cy0, 4); cmp("b2b.in_frame", f0, 1);
    idle(3); cy(0, 1);
    cmp("b2b.done2", d0, 1); cmp("b2b.cycles2", cy0, 5); cmp("b2b.count", fc0, 2);
    rst_pulse("rst2");
    // one-cycle frames, orphan end, clear
    for (int k = 1; k <= 3; k++) begin
      cy(1, 1);
      cmp("one.done", d0, 1); cmp("one.cycles", cy0, 1); cmp("one.count", fc0, k);
    end
    cy(0, 1);
    cmp("orphan.flag", o0, 1); cmp("orphan.count", fc0, 3); cmp("orphan.nodone", d0, 0);
    cy(0, 0, 1);
    cmp("orphan.clr", o0, 0);
    rst_pulse("rst3");
    // overlap: start@0, start@4, end@6
    cy(1, 0); idle(3); cy(1, 0);
    cmp("ovl.flag", v0, 1);
    idle(1); cy(0, 1);
    cmp("ovl.done", d0, 1); cmp("ovl.cycles", cy0, 3); cmp("ovl.count", fc0, 1);
    rst_pulse("rst4");
    // timeout on u1 (TIMEOUT=8)
    cy(1, 0); idle(6); cy(0, 1);
    cmp("to.done_max", d1, 1); cmp("to.cycles_max", cy1, 8); cmp("to.no_err", t1, 0);
    idle(12); cy(1, 0); idle(7);
    cmp("to.open", f1, 1); cmp("to.not_yet", t1, 0);
    cy(0, 1);
    cmp("to.flag", t1, 1); cmp("to.idle", f1, 0); cmp("to.nodone", d1, 0);
    cmp("to.no_orphan", o1, 0); cmp("to.count", fc1, 1);
    rst_pulse("rst5");
    // wrap on u1 (FRM_W=2), then reset mid-frame
    for (int k = 1; k <= 4; k++) begin
      cy(1, 1);
      cmp("wrap.count", fc1, k % 4);
    end
    cy(1, 0); idle(2);
    cmp("wrap.open", f1, 1);
    rst_pulse("rst_mid");
    cy(0, 1);
    cmp("post_rst.orphan_u1", o1, 1); cmp("post_rst.orphan_u0", o0, 1);
    idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
